// File: rtl/risc_controller.sv
// Eight-phase instruction sequencer for a small accumulator RISC, with optional fetch wait states.
// Optional single-step hold after STORE is enabled by defining RISC_CTRL_STEP_EN (adds the step input).
module risc_controller #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
`ifdef RISC_CTRL_STEP_EN
    input  logic       step,
`endif
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Wait counts beyond 3 are not meaningful for the memory, so they saturate.
    localparam int         WAIT_CLAMP = (MEM_WAIT > 3) ? 3 : MEM_WAIT;
    localparam logic [1:0] WAIT_MAX   = WAIT_CLAMP[1:0];

    phase_t     r_phase;
    logic       r_halt;
    logic [1:0] r_wait;
    phase_t     w_phase_nxt;
    logic       w_halt_nxt;
    logic [1:0] w_wait_nxt;
    logic       w_aluop;
`ifdef RISC_CTRL_STEP_EN
    logic       r_hold;
    logic       w_hold_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= INST_ADDR;
            r_halt  <= 1'b0;
            r_wait  <= 2'd0;
`ifdef RISC_CTRL_STEP_EN
            r_hold  <= 1'b0;
`endif
        end else begin
            r_phase <= w_phase_nxt;
            r_halt  <= w_halt_nxt;
            r_wait  <= w_wait_nxt;
`ifdef RISC_CTRL_STEP_EN
            r_hold  <= w_hold_nxt;
`endif
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_halt_nxt  = r_halt;
        w_wait_nxt  = r_wait;
`ifdef RISC_CTRL_STEP_EN
        w_hold_nxt  = r_hold;
`endif
        if (!r_halt) begin
            case (r_phase)
                INST_ADDR: begin
`ifdef RISC_CTRL_STEP_EN
                    // The hold only applies after a completed instruction, not after reset.
                    if (!r_hold || step) begin
                        w_phase_nxt = INST_FETCH;
                        w_hold_nxt  = 1'b0;
                    end
`else
                    w_phase_nxt = INST_FETCH;
`endif
                end
                INST_FETCH, OP_FETCH: begin
                    if (r_wait != WAIT_MAX) begin
                        w_wait_nxt = r_wait + 2'd1;
                    end else begin
                        w_wait_nxt  = 2'd0;
                        w_phase_nxt = phase_t'(r_phase + 3'd1);
                    end
                end
                OP_ADDR: begin
                    if (opcode == OP_HLT) begin
                        w_halt_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = OP_FETCH;
                    end
                end
                STORE: begin
                    w_phase_nxt = INST_ADDR;
`ifdef RISC_CTRL_STEP_EN
                    w_hold_nxt  = 1'b1;
`endif
                end
                default: w_phase_nxt = phase_t'(r_phase + 3'd1);
            endcase
        end
    end

    assign w_aluop = (opcode >= 3'd2) && (opcode <= 3'd5);

    // Outputs are gated by rst directly so they drop the moment reset asserts.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (!rst) begin
            halt = 1'b0;
        end else if (r_halt) begin
            halt = 1'b1;
        end else begin
            case (r_phase)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: rd = w_aluop;
                ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                    wr     = (opcode == OP_STO);
                end
                default: sel = 1'b0;
            endcase
        end
    end

    assign phase = r_phase;

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench for risc_controller: three instances (MEM_WAIT 0, 2, 5) share the stimulus,
// and a timeline model of each instruction predicts every output per clock.
module tb_risc_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       step;

`ifdef RISC_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    // Per instance: {phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
    logic [11:0] v0, v2, v5;
    logic [35:0] exp_q[$];
    logic [35:0] mon_exp;
    logic [35:0] mon_act;

    int n_checks = 0;
    int n_pass   = 0;

    int wk[3]     = '{0, 2, 3};
    int m_t[3]    = '{0, 0, 0};
    bit m_halt[3] = '{0, 0, 0};
    bit m_hold[3] = '{0, 0, 0};

    risc_controller #(.MEM_WAIT(0)) u_w0 (
        .clk(clk), .rst(rst),
`ifdef RISC_CTRL_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .zero(zero),
        .sel(v0[8]), .rd(v0[7]), .wr(v0[6]), .ld_ir(v0[5]), .ld_ac(v0[4]),
        .ld_pc(v0[3]), .inc_pc(v0[2]), .data_e(v0[1]), .halt(v0[0]), .phase(v0[11:9])
    );

    risc_controller #(.MEM_WAIT(2)) u_w2 (
        .clk(clk), .rst(rst),
`ifdef RISC_CTRL_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .zero(zero),
        .sel(v2[8]), .rd(v2[7]), .wr(v2[6]), .ld_ir(v2[5]), .ld_ac(v2[4]),
        .ld_pc(v2[3]), .inc_pc(v2[2]), .data_e(v2[1]), .halt(v2[0]), .phase(v2[11:9])
    );

    risc_controller #(.MEM_WAIT(5)) u_w5 (
        .clk(clk), .rst(rst),
`ifdef RISC_CTRL_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .zero(zero),
        .sel(v5[8]), .rd(v5[7]), .wr(v5[6]), .ld_ir(v5[5]), .ld_ac(v5[4]),
        .ld_pc(v5[3]), .inc_pc(v5[2]), .data_e(v5[1]), .halt(v5[0]), .phase(v5[11:9])
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Position t within an instruction of 8+2w clocks mapped to its phase.
    function automatic int phase_of(input int t, input int w);
        if (t == 0)         return 0;
        if (t <= 1 + w)     return 1;
        if (t <= w + 4)     return t - w;
        if (t <= 2 * w + 5) return 5;
        return t - 2 * w;
    endfunction

    function automatic logic [11:0] exp_vec(input int w, input int t, input bit halted,
                                            input logic r, input logic [2:0] op, input logic z);
        int         ph;
        logic [2:0] phb;
        bit         alu;
        logic [11:0] v;
        v = 12'd0;
        if (!r) return v;
        if (halted) return {3'd4, 9'b0_0000_0001};
        ph  = phase_of(t, w);
        phb = ph[2:0];
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        v[11:9] = phb;
        v[8] = (ph <= 3);
        v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        v[6] = (ph == 7) && (op == 3'd6);
        v[5] = (ph == 2) || (ph == 3);
        v[4] = (ph == 7) && alu;
        v[3] = (ph >= 6) && (op == 3'd7);
        v[2] = (ph == 4) || (ph == 6 && op == 3'd1 && z);
        v[1] = (ph >= 6) && (op == 3'd6);
        v[0] = (ph == 4) && (op == 3'd0);
        return v;
    endfunction

    // Driver: advance the model on the edge with the inputs held over the past cycle,
    // then apply new inputs and queue the outputs they should produce.
    task automatic tick(input logic n_rst, input logic [2:0] n_op, input logic n_zero,
                        input logic n_step);
        int per;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst && !m_halt[k]) begin
                per = 8 + 2 * wk[k];
                if (phase_of(m_t[k], wk[k]) == 4 && opcode == 3'd0) begin
                    m_halt[k] = 1'b1;
                end else if (m_t[k] == 0 && m_hold[k]) begin
                    if (step) begin
                        m_t[k]    = 1;
                        m_hold[k] = 1'b0;
                    end
                end else begin
                    m_t[k] = m_t[k] + 1;
                    if (m_t[k] == per) begin
                        m_t[k]    = 0;
                        m_hold[k] = STEP_EN;
                    end
                end
            end
        end
        #1;
        rst    = n_rst;
        opcode = n_op;
        zero   = n_zero;
        step   = n_step;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                m_t[k]    = 0;
                m_halt[k] = 1'b0;
                m_hold[k] = 1'b0;
            end
        end
        exp_q.push_back({exp_vec(wk[2], m_t[2], m_halt[2], rst, opcode, zero),
                         exp_vec(wk[1], m_t[1], m_halt[1], rst, opcode, zero),
                         exp_vec(wk[0], m_t[0], m_halt[0], rst, opcode, zero)});
    endtask

    // Scoreboard monitor: every falling edge presents one output sample per instance.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {v5, v2, v0};
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (mon_act[k*12 +: 12] === mon_exp[k*12 +: 12]) begin
                        n_pass++;
                    end else begin
                        $display("FAIL outputs_inst%0d t=%0t actual=%h expected=%h (op=%0d zero=%0b rst=%0b)",
                                 k, $time, mon_act[k*12 +: 12], mon_exp[k*12 +: 12], opcode, zero, rst);
                    end
                end
            end
        end
    end

    initial begin
        rst    = 1'b0;
        opcode = 3'd0;
        zero   = 1'b0;
        step   = 1'b0;

        // Reset state
        repeat (3) tick(1'b0, 3'd0, 1'b0, 1'b0);

        // Each non-halting opcode held across two full instructions
        for (int op = 1; op < 8; op++) begin
            tick(1'b0, 3'(op), 1'b0, 1'b1);
            repeat (30) tick(1'b1, 3'(op), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Halt, then reset while halted and restart
        tick(1'b0, 3'd0, 1'b0, 1'b1);
        repeat (30) tick(1'b1, 3'd0, 1'($urandom_range(0, 1)), 1'b1);
        tick(1'b0, 3'd0, 1'b0, 1'b1);
        repeat (20) tick(1'b1, 3'd2, 1'b0, 1'b1);

        // Random traffic with occasional async resets and rare halts
        repeat (600) begin
            tick(1'($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 24) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0));
        end

        // Single-step hold: no step for a while, then one pulse
        tick(1'b0, 3'd2, 1'b0, 1'b0);
        repeat (40) tick(1'b1, 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), 1'b0);
        tick(1'b1, 3'd6, 1'b0, 1'b1);
        repeat (30) tick(1'b1, 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/risc_controller.md
RISC_CONTROLLER -- requirements
Module: risc_controller

Interface
REQ-001 The parameter MEM_WAIT SHALL default to 0 and SHALL set the number of extra wait cycles (legal range 0..3) inserted in each memory fetch phase.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single system clock; all state changes on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-004 The port opcode SHALL be an input, 3 bits wide, carrying the instruction register opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-005 The port zero SHALL be an input, 1 bit wide, and is high when the accumulator equals 0.
REQ-006 The port sel SHALL be an output, 1 bit wide; 1 selects the PC onto the memory address bus and 0 selects the IR operand.
REQ-007 The outputs rd, wr, ld_ir, ld_ac, ld_pc, inc_pc and data_e SHALL each be 1 bit wide, meaning respectively: memory read, memory write, IR load, accumulator load, PC load, PC increment, and data-bus drive enable.
REQ-008 The port halt SHALL be an output, 1 bit wide, and is high while the processor is halted.
REQ-009 The port phase SHALL be an output, 3 bits wide, giving the current phase for debug.
REQ-010 The port step SHALL be an input, 1 bit wide, a single-step advance pulse, and SHALL exist only when RISC_CTRL_STEP_EN is defined.

Function
REQ-011 The controller SHALL sequence eight phases in order: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7); it wraps from 7 to 0 and advances once per clock otherwise.
REQ-012 Outputs SHALL be decoded combinationally from the registered phase, opcode, zero and halt state; no output is registered.
REQ-013 In phases 0-3, sel=1; rd=1 in phases 1-3; ld_ir=1 in phases 2-3.
REQ-014 In OP_ADDR, inc_pc=1 for every opcode, and halt=1 when opcode=HLT.
REQ-015 rd=1 in phases 5-7 when opcode is one of ADD, AND, XOR or LDA (ALUOP); ld_ac=1 in phase 7 only, for ALUOP.
REQ-016 In ALU_OP, inc_pc=1 when opcode=SKZ and zero=1.
REQ-017 ld_pc=1 in phases 6-7 for JMP.
REQ-018 For STO, data_e=1 in phases 6-7, and wr=1 in phase 7 only.
REQ-019 All outputs not listed for a phase and opcode SHALL be 0; rd and wr SHALL never be high together.
REQ-020 Halt SHALL be latched on the clock edge ending OP_ADDR with opcode=HLT; once latched, halt=1, phase stays at 4, and all other outputs are 0 until reset.
REQ-021 When MEM_WAIT=N, phases INST_FETCH and OP_FETCH SHALL each last N+1 clocks, with a wait counter and with their outputs held constant throughout; the instruction period is 8+2N clocks.
REQ-022 A MEM_WAIT value above 3 SHALL be clamped to 3.

Reset
REQ-023 Asserting rst low SHALL immediately, without waiting for a clock edge, force phase=0, clear the halt latch and wait counter, and drive every output, including sel and halt, to 0.
REQ-024 After rst deasserts, the first rising edge SHALL enter INST_FETCH; the phase-0 outputs (sel=1) appear as soon as rst goes high.
REQ-025 Reset asserted in any phase, including mid-wait or while halted, SHALL abandon the current instruction with no partial wr pulse surviving.

Configuration
REQ-026 When RISC_CTRL_STEP_EN is defined, after STORE the controller SHALL hold in INST_ADDR, with sel=1 and all other outputs 0, until a clock edge samples step=1, then proceed.
REQ-027 With RISC_CTRL_STEP_EN defined, step during any other phase SHALL be ignored.
REQ-028 When RISC_CTRL_STEP_EN is undefined, the step port SHALL be absent and the controller free-runs per REQ-011.

Verification
REQ-029 Scenario HLT: opcode=0, release rst -> halt=0 after edges 1-3, halt=1 from edge 4 onward, phase stuck at 4 for 20 further clocks.
REQ-030 Scenario JMP and SKZ: opcode=7 -> ld_pc=1 exactly in phases 6-7 and inc_pc only in phase 4; opcode=1 with zero=1 -> inc_pc in phases 4 and 6; with zero=0 -> inc_pc in phase 4 only.
REQ-031 Scenario STO and ADD: opcode=6 -> data_e in phases 6-7, wr only in phase 7, rd=0 in phases 5-7; opcode=2 -> rd in phases 5-7, ld_ac only in phase 7.
REQ-032 Scenario wait states: MEM_WAIT=2 -> 12-clock instruction period, rd held during 3-cycle INST_FETCH and OP_FETCH; MEM_WAIT=5 -> same as 3.
REQ-033 Scenario async reset: rst low mid-OP_FETCH and again while halted -> all outputs 0 before the next edge; restart at phase 0 with halt=0.
REQ-034 Scenario step (macro defined): step=0 for 10 clocks after STORE -> phase stays 0; one step pulse -> the next instruction runs 8 clocks and holds again.
